// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
//  Module   : pc_unit
//  Purpose  : Program-counter stage. Holds the program-memory fetch address,
//             steps it, loads jump targets from the data bus, and handles
//             subroutine call/return through a small LIFO of return
//             addresses.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    AW      address width (matches the IR operand field)
//    DEPTH   return-stack entries, power of two, minimum 2
//    RST_PC  PC value after reset
//  Ports
//    clk        in   1   system clock, rising edge
//    clr_n      in   1   asynchronous active-low reset
//    c0         in   2   00 hold, 01 increment, 10 load bus_in, 11 return
//    call       in   1   push pc+1 and load bus_in; overrides c0
//    bus_in     in   AW  jump / call target
//    pc         out  AW  current fetch address
//    stk_empty  out  1   return stack holds no entries
//    stk_full   out  1   return stack holds DEPTH entries
//    fault      out  1   sticky overflow / underflow flag
//  Configuration
//    PC_STACK_EN  define to build the return stack. Without it, call is a
//                 plain load, c0=11 holds, and the status flags are tied
//                 off (stk_empty=1, stk_full=0, fault=0).
// ============================================================================
module pc_unit #(
    parameter int              AW     = 6,
    parameter int              DEPTH  = 4,
    parameter logic [AW-1:0]   RST_PC = '0
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic [1:0]    c0,
    input  logic          call,
    input  logic [AW-1:0] bus_in,
    output logic [AW-1:0] pc,
    output logic          stk_empty,
    output logic          stk_full,
    output logic          fault
);

    // ------------------------------------------------------------------
    // PC control encodings
    // ------------------------------------------------------------------
    localparam logic [1:0]    C_CTL_HOLD = 2'b00;
    localparam logic [1:0]    C_CTL_INC  = 2'b01;
    localparam logic [1:0]    C_CTL_LOAD = 2'b10;
    localparam logic [1:0]    C_CTL_RET  = 2'b11;
    localparam logic [AW-1:0] C_PC_ONE   = AW'(1);

    logic [AW-1:0] pc_q;
    logic [AW-1:0] pc_d;
    logic [AW-1:0] w_pc_inc;

    // Natural modulo-2^AW wrap: all-ones steps to zero with no flag.
    assign w_pc_inc = pc_q + C_PC_ONE;
    assign pc       = pc_q;

`ifdef PC_STACK_EN
    // ------------------------------------------------------------------
    // Return stack: register file plus an occupancy pointer one bit wider
    // than the index, so "full" (== DEPTH) is distinguishable from empty.
    // ------------------------------------------------------------------
    localparam int             IW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int             PW         = IW + 1;
    localparam logic [PW-1:0]  C_SP_ONE   = PW'(1);
    localparam logic [PW-1:0]  C_SP_FULL  = PW'(DEPTH);
    localparam logic [IW-1:0]  C_IDX_ONE  = IW'(1);

    logic [PW-1:0] sp_q;
    logic [PW-1:0] sp_d;
    logic          fault_q;
    logic          fault_d;
    logic [AW-1:0] stk_q [DEPTH];

    logic          w_push_en;
    logic          w_empty;
    logic          w_full;
    logic [IW-1:0] w_push_idx;
    logic [IW-1:0] w_pop_idx;

    assign w_empty    = (sp_q == '0);
    assign w_full     = (sp_q == C_SP_FULL);
    // Low index bits address the next free slot; the top entry sits one
    // below it. When full the low bits are zero and the subtraction wraps
    // to DEPTH-1, which is exactly the top slot.
    assign w_push_idx = sp_q[IW-1:0];
    assign w_pop_idx  = sp_q[IW-1:0] - C_IDX_ONE;

    always_comb begin
        pc_d      = pc_q;
        sp_d      = sp_q;
        fault_d   = fault_q;
        w_push_en = 1'b0;
        if (call) begin
            // Call always redirects; the push is dropped when full so the
            // existing entries survive and the overflow is flagged.
            pc_d = bus_in;
            if (w_full) begin
                fault_d = 1'b1;
            end else begin
                w_push_en = 1'b1;
                sp_d      = sp_q + C_SP_ONE;
            end
        end else begin
            // Any code not matched (including X/Z during the control
            // unit's start-up window) falls through to hold.
            case (c0)
                C_CTL_RET: begin
                    if (w_empty) begin
                        fault_d = 1'b1;
                    end else begin
                        pc_d = stk_q[w_pop_idx];
                        sp_d = sp_q - C_SP_ONE;
                    end
                end
                C_CTL_LOAD: pc_d = bus_in;
                C_CTL_INC:  pc_d = w_pc_inc;
                C_CTL_HOLD: pc_d = pc_q;
                default:    pc_d = pc_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            pc_q    <= RST_PC;
            sp_q    <= '0;
            fault_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            fault_q <= fault_d;
        end
    end

    // Stack contents are don't-care after reset, so no reset term here.
    always_ff @(posedge clk) begin
        if (w_push_en) begin
            stk_q[w_push_idx] <= w_pc_inc;
        end
    end

    assign stk_empty = w_empty;
    assign stk_full  = w_full;
    assign fault     = fault_q;

`else
    // ------------------------------------------------------------------
    // Stackless build: call degenerates to a load, return to hold.
    // ------------------------------------------------------------------
    always_comb begin
        pc_d = pc_q;
        if (call) begin
            pc_d = bus_in;
        end else begin
            case (c0)
                C_CTL_LOAD: pc_d = bus_in;
                C_CTL_INC:  pc_d = w_pc_inc;
                C_CTL_RET:  pc_d = pc_q;
                C_CTL_HOLD: pc_d = pc_q;
                default:    pc_d = pc_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            pc_q <= RST_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign stk_empty = 1'b1;
    assign stk_full  = 1'b0;
    assign fault     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_unit
//  Purpose  : Self-checking bench for pc_unit. Directed scenarios followed by
//             randomized control traffic, each cycle compared against a
//             queue-based reference model of the program counter and its
//             return stack.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pc_unit;

    localparam int          AW     = 6;
    localparam int          DEPTH  = 4;
    localparam logic [AW-1:0] RST_PC = '0;
    localparam int          MODN   = 1 << AW;

    logic          clk;
    logic          clr_n;
    logic [1:0]    c0;
    logic          call;
    logic [AW-1:0] bus_in;
    logic [AW-1:0] pc;
    logic          stk_empty;
    logic          stk_full;
    logic          fault;

    pc_unit #(
        .AW     (AW),
        .DEPTH  (DEPTH),
        .RST_PC (RST_PC)
    ) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .c0        (c0),
        .call      (call),
        .bus_in    (bus_in),
        .pc        (pc),
        .stk_empty (stk_empty),
        .stk_full  (stk_full),
        .fault     (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // ------------------------------------------------------------------
    // Reference model: architectural PC, a queue as the LIFO, sticky fault
    // ------------------------------------------------------------------
    int m_pc;
    int m_stk[$];
    bit m_fault;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc    = int'(RST_PC);
        m_stk   = {};
        m_fault = 1'b0;
    endtask

    task automatic model_apply(input bit cl, input logic [1:0] c, input int b);
`ifdef PC_STACK_EN
        if (cl) begin
            if (m_stk.size() < DEPTH) m_stk.push_back((m_pc + 1) % MODN);
            else                      m_fault = 1'b1;
            m_pc = b;
        end else if (c == 2'b11) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else                  m_fault = 1'b1;
        end else if (c == 2'b10) begin
            m_pc = b;
        end else if (c == 2'b01) begin
            m_pc = (m_pc + 1) % MODN;
        end
`else
        if (cl)               m_pc = b;
        else if (c == 2'b10)  m_pc = b;
        else if (c == 2'b01)  m_pc = (m_pc + 1) % MODN;
`endif
    endtask

    task automatic compare_all(input string tag);
`ifdef PC_STACK_EN
        check({tag, ".pc"},    32'(pc),        32'(m_pc));
        check({tag, ".empty"}, 32'(stk_empty), 32'(m_stk.size() == 0));
        check({tag, ".full"},  32'(stk_full),  32'(m_stk.size() == DEPTH));
        check({tag, ".fault"}, 32'(fault),     32'(m_fault));
`else
        check({tag, ".pc"},    32'(pc),        32'(m_pc));
        check({tag, ".empty"}, 32'(stk_empty), 32'd1);
        check({tag, ".full"},  32'(stk_full),  32'd0);
        check({tag, ".fault"}, 32'(fault),     32'd0);
`endif
    endtask

    // Inputs are applied 1 time unit after a rising edge; outputs are
    // sampled 1 time unit after the next one.
    task automatic step(input string tag, input bit cl, input logic [1:0] c, input int b);
        call   = cl;
        c0     = c;
        bus_in = AW'(b);
        @(posedge clk);
        model_apply(cl, c, b);
        #1;
        compare_all(tag);
    endtask

    task automatic do_reset(input string tag);
        clr_n = 1'b0;
        call  = 1'b0;
        c0    = 2'b00;
        #1;
        model_reset();
        compare_all(tag);
        @(posedge clk);
        #1;
        clr_n = 1'b1;
    endtask

    initial begin
        clr_n  = 1'b1;
        call   = 1'b0;
        c0     = 2'b00;
        bus_in = '0;
        model_reset();
        #2;

        // Reset and step
        do_reset("rst");
        step("step1", 1'b0, 2'b01, 0); check("step1.const", 32'(pc), 32'd1);
        step("step2", 1'b0, 2'b01, 0); check("step2.const", 32'(pc), 32'd2);
        step("step3", 1'b0, 2'b01, 0); check("step3.const", 32'(pc), 32'd3);

        // Asynchronous reset mid-cycle: pc returns to RST_PC before any edge
        c0 = 2'b01;
        #2;
        clr_n = 1'b0;
        #1;
        check("async_rst.pc", 32'(pc), 32'(RST_PC));
        model_reset();
        @(posedge clk);
        #1;
        check("async_rst.hold", 32'(pc), 32'(RST_PC));
        clr_n = 1'b1;

        // Wrap
        step("wrap.load", 1'b0, 2'b10, 63);
        step("wrap.inc",  1'b0, 2'b01, 0);
        check("wrap.const", 32'(pc), 32'd0);
        check("wrap.fault", 32'(fault), 32'd0);

        // Jump then hold
        step("jmp.pre", 1'b0, 2'b10, 5);
        step("jmp",     1'b0, 2'b10, 42);
        check("jmp.const", 32'(pc), 32'd42);
        for (int i = 0; i < 4; i++) step("hold", 1'b0, 2'b00, $urandom_range(0, 63));
        check("hold.const", 32'(pc), 32'd42);

        // Nested call / return
        step("nest.pre",   1'b0, 2'b10, 10);
        step("nest.call1", 1'b1, 2'b01, 20);
        step("nest.call2", 1'b1, 2'b11, 30);
        step("nest.ret1",  1'b0, 2'b11, 0);
        step("nest.ret2",  1'b0, 2'b11, 0);
`ifdef PC_STACK_EN
        check("nest.const", 32'(pc), 32'd11);
        check("nest.empty", 32'(stk_empty), 32'd1);
`else
        check("nest.const", 32'(pc), 32'd30);
`endif

        // Overflow: five calls into a four-deep stack, then unwind
        for (int i = 0; i < 5; i++) step("ovf.call", 1'b1, 2'b00, 8 * i + 3);
        check("ovf.pc", 32'(pc), 32'd35);
        for (int i = 0; i < 5; i++) step("ovf.ret", 1'b0, 2'b11, 0);

        // Underflow straight out of reset
        do_reset("udf.rst");
        step("udf", 1'b0, 2'b11, 0);
        check("udf.pc", 32'(pc), 32'(RST_PC));

        // Randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            int r;
            bit cl;
            r  = int'($urandom_range(0, 99));
            cl = ($urandom_range(0, 5) == 0);
            if (r < 2) begin
                do_reset("rnd.rst");
            end else begin
                step("rnd", cl, 2'($urandom_range(0, 3)), int'($urandom_range(0, MODN - 1)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
